// File: rtl/mmio_monitor_pkg.sv
// Shared register map and state encoding for the MMIO test monitor.
// Offsets are byte offsets inside the 32-byte window.
package mmio_monitor_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_END    = 5'h04;
    localparam logic [4:0] OFF_CYCLE  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_LOG    = 5'h10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] WIN_BYTES = 32'd32;

    // True when addr falls inside [base, base+WIN_BYTES-1]; the unsigned
    // difference wraps for addresses below base, so one compare covers both ends.
    function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] rel;
        rel = addr - base;
        return rel < WIN_BYTES;
    endfunction

endpackage

// File: rtl/mmio_log_fifo.sv
// Show-ahead log FIFO: head entry is visible on dout whenever not empty.
// A push while full is dropped unless a pop frees a slot in the same cycle.
module mmio_log_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        // DEPTH is a power of two, so pointers wrap naturally
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_monitor.sv
// Memory-mapped test monitor: watches CPU stores to a 32-byte window, tracks
// run/done status, counts RUN cycles and logs values into a FIFO.
module mmio_monitor
    import mmio_monitor_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          LOG_DEPTH = 8,
    parameter logic [31:0] PASS_CODE = 32'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        log_pop,
    output logic        mmio_sel,
    output logic [31:0] mmio_rdata,
    output logic        done,
    output logic        pass,
    output logic [31:0] result,
    output logic [31:0] cycle_count,
    output logic        log_valid,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(LOG_DEPTH + 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   result_q, result_d;
    logic          pass_q, pass_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rel_adr;
    logic [4:0]    off;
    logic          wr_ok;
    logic          log_push;
    logic          log_full;
    logic          log_empty;
    logic [CW-1:0] log_count;
    logic [31:0]   status;

    assign rel_adr  = DataAdr - BASE_ADDR;
    assign off      = rel_adr[4:0];
    assign mmio_sel = win_hit(DataAdr, BASE_ADDR);
    // DONE is terminal until reset: every store is dropped there
    assign wr_ok    = MemWrite & mmio_sel & (DataAdr[1:0] == 2'b00) & (state_q != ST_DONE);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        pass_d   = pass_q;
        log_push = 1'b0;
        if (wr_ok) begin
            case (off)
                OFF_CTRL: begin
                    if (state_q == ST_IDLE && WriteData[0]) begin
                        state_d = ST_RUN;
                    end else if (state_q == ST_RUN && !WriteData[0]) begin
                        state_d = ST_IDLE;
                    end
                end
                OFF_END: begin
                    state_d  = ST_DONE;
                    result_d = WriteData;
                    pass_d   = (WriteData == PASS_CODE);
                end
                OFF_LOG:  log_push = 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        cycle_d = cycle_q;
        if (state_q == ST_RUN && cycle_q != 32'hFFFF_FFFF) begin
            cycle_d = cycle_q + 32'd1;
        end
        ovf_d = ovf_q | (log_push & log_full & ~(log_pop & ~log_empty));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            pass_q   <= 1'b0;
            cycle_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            cycle_q  <= cycle_d;
            ovf_q    <= ovf_d;
        end
    end

    mmio_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (32)
    ) u_log_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (log_push),
        .din   (WriteData),
        .pop   (log_pop),
        .dout  (log_data),
        .count (log_count),
        .full  (log_full),
        .empty (log_empty)
    );

    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign result       = result_q;
    assign cycle_count  = cycle_q;
    assign log_valid    = ~log_empty;
    assign log_overflow = ovf_q;
    assign dbg_state    = state_q;

    always_comb begin
        status          = '0;
        status[2:0]     = {ovf_q, pass_q, done};
        status[CW+2:3]  = log_count;
        mmio_rdata      = '0;
        if (mmio_sel) begin
            case (off)
                OFF_CTRL:   mmio_rdata = {31'b0, state_q == ST_RUN};
                OFF_END:    mmio_rdata = result_q;
                OFF_CYCLE:  mmio_rdata = cycle_q;
                OFF_STATUS: mmio_rdata = status;
                default:    mmio_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_monitor.sv
// Directed bench for mmio_monitor: run counter, END/pass, log FIFO,
// address filtering and asynchronous reset behaviour.
module tb_mmio_monitor;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_END    = BASE + 32'h04;
    localparam logic [31:0] A_CYCLE  = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_LOG    = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = BASE;
    logic [31:0] WriteData = '0;
    logic        log_pop = 1'b0;
    logic        mmio_sel;
    logic [31:0] mmio_rdata;
    logic        done;
    logic        pass;
    logic [31:0] result;
    logic [31:0] cycle_count;
    logic        log_valid;
    logic [31:0] log_data;
    logic        log_overflow;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    mmio_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .log_pop      (log_pop),
        .mmio_sel     (mmio_sel),
        .mmio_rdata   (mmio_rdata),
        .done         (done),
        .pass         (pass),
        .result       (result),
        .cycle_count  (cycle_count),
        .log_valid    (log_valid),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        reset    = 1'b0;
        MemWrite = 1'b0;
        log_pop  = 1'b0;
        DataAdr  = BASE;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        DataAdr = addr;
        #1 check(tag, mmio_rdata, exp);
        DataAdr = BASE;
    endtask

    // drivers
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        DataAdr   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = BASE;
    endtask

    task automatic pop_one();
        log_pop = 1'b1;
        @(posedge clk);
        #1 log_pop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_log_valid", {31'b0, log_valid}, 32'd0);
        check("rst_ovf", {31'b0, log_overflow}, 32'd0);
        check_rd("rst_ctrl_rd", A_CTRL, 32'd0);

        // 10 RUN cycles, then hold; re-entering RUN keeps counting
        wr(A_CTRL, 32'd1);
        check_rd("run_ctrl_rd", A_CTRL, 32'd1);
        idle(9);
        wr(A_CTRL, 32'd0);
        check("cycle_10", cycle_count, 32'd10);
        check_rd("stop_ctrl_rd", A_CTRL, 32'd0);
        idle(5);
        check_rd("cycle_hold_rd", A_CYCLE, 32'd10);
        wr(A_CTRL, 32'd1);
        idle(2);
        wr(A_CTRL, 32'd0);
        check("cycle_resume", cycle_count, 32'd13);

        // END with pass code, later writes ignored
        check("pre_end_done", {31'b0, done}, 32'd0);
        wr(A_END, 32'd5);
        check("end5_done", {31'b0, done}, 32'd1);
        check("end5_pass", {31'b0, pass}, 32'd1);
        check("end5_result", result, 32'd5);
        check("end5_state", {30'b0, dbg_state}, 32'd2);
        wr(A_END, 32'd7);
        wr(A_CTRL, 32'd1);
        wr(A_LOG, 32'h55);
        check("end7_result", result, 32'd5);
        check("end7_pass", {31'b0, pass}, 32'd1);
        check_rd("done_ctrl_rd", A_CTRL, 32'd0);
        check("done_log_ignored", {31'b0, log_valid}, 32'd0);
        check_rd("end5_status", A_STATUS, 32'h3);
        check_rd("end5_result_rd", A_END, 32'd5);

        // END with failing code
        do_reset();
        wr(A_END, 32'd3);
        check("end3_done", {31'b0, done}, 32'd1);
        check("end3_pass", {31'b0, pass}, 32'd0);
        check_rd("end3_status", A_STATUS, 32'h1);

        // overflow: 9 pushes into 8 entries
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            wr(A_LOG, 32'(i));
            if (i <= 8) exp_q.push_back(32'(i));
        end
        check_rd("ovf_status", A_STATUS, 32'h44);
        check("ovf_flag", {31'b0, log_overflow}, 32'd1);
        while (exp_q.size() > 0) begin
            check("ovf_valid", {31'b0, log_valid}, 32'd1);
            check("ovf_pop_data", log_data, exp_q.pop_front());
            pop_one();
        end
        check("drain_valid", {31'b0, log_valid}, 32'd0);
        check("drain_data", log_data, 32'd0);
        pop_one();
        check_rd("empty_pop_status", A_STATUS, 32'h4);

        // push+pop when empty: only the push takes effect
        DataAdr   = A_LOG;
        WriteData = 32'hAA;
        MemWrite  = 1'b1;
        log_pop   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        log_pop  = 1'b0;
        DataAdr  = BASE;
        check("pp_empty_valid", {31'b0, log_valid}, 32'd1);
        check("pp_empty_data", log_data, 32'hAA);
        check_rd("pp_empty_status", A_STATUS, 32'hC);

        // push+pop when full: both happen, no overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(A_LOG, 32'h10 + 32'(i));
            exp_q.push_back(32'h10 + 32'(i));
        end
        DataAdr   = A_LOG;
        WriteData = 32'h99;
        MemWrite  = 1'b1;
        log_pop   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        log_pop  = 1'b0;
        DataAdr  = BASE;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h99);
        check_rd("pp_full_status", A_STATUS, 32'h40);
        check("pp_full_ovf", {31'b0, log_overflow}, 32'd0);
        while (exp_q.size() > 0) begin
            check("pp_full_data", log_data, exp_q.pop_front());
            pop_one();
        end
        check("pp_full_drained", {31'b0, log_valid}, 32'd0);

        // address filtering
        do_reset();
        wr(BASE + 32'h6, 32'd5);
        check("misalign_end", {31'b0, done}, 32'd0);
        wr(BASE + 32'h2, 32'd1);
        check_rd("misalign_ctrl", A_CTRL, 32'd0);
        DataAdr = BASE + 32'h20;
        #1 check("outside_sel", {31'b0, mmio_sel}, 32'd0);
        check("outside_rdata", mmio_rdata, 32'd0);
        wr(BASE + 32'h20, 32'd1);
        DataAdr = BASE + 32'h1C;
        #1 check("top_edge_sel", {31'b0, mmio_sel}, 32'd1);
        DataAdr = BASE - 32'h4;
        #1 check("below_sel", {31'b0, mmio_sel}, 32'd0);
        DataAdr = BASE;
        check("outside_state", {30'b0, dbg_state}, 32'd0);
        check("outside_cycle", cycle_count, 32'd0);

        // asynchronous reset mid-RUN with 3 log entries
        do_reset();
        wr(A_CTRL, 32'd1);
        wr(A_LOG, 32'hA1);
        wr(A_LOG, 32'hA2);
        wr(A_LOG, 32'hA3);
        idle(2);
        #2 reset = 1'b0;
        #1;
        check("arst_state", {30'b0, dbg_state}, 32'd0);
        check("arst_cycle", cycle_count, 32'd0);
        check("arst_log_valid", {31'b0, log_valid}, 32'd0);
        check("arst_log_data", log_data, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check_rd("arst_status", A_STATUS, 32'd0);
        reset = 1'b1;
        wr(A_CTRL, 32'd1);
        check_rd("first_edge_write", A_CTRL, 32'd1);
        check("post_rst_log_valid", {31'b0, log_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
